// File: rtl/gamma_lut_ctrl_if.sv
//------------------------------------------------------------------------------
// Module      : gamma_lut_ctrl_if
// Description : Host stream, control and gamma write-bus bundle for gamma_lut_ctrl.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

interface gamma_lut_ctrl_if #(
    parameter int AW = 10
);
    logic          gamma_present;
    logic          en_req;
    logic          load_start;
    logic          load_abort;
    logic          s_valid;
    logic [7:0]    s_data;
    logic          s_ready;
    logic          busy;
    logic          done;
    logic          gamma_en;
    logic          gamma_wr;
    logic [AW-1:0] gamma_wr_addr;
    logic [7:0]    gamma_value;
    logic [15:0]   checksum;

    // Host / system side
    modport master (
        output gamma_present, en_req, load_start, load_abort, s_valid, s_data,
        input  s_ready, busy, done, gamma_en, gamma_wr, gamma_wr_addr, gamma_value, checksum
    );

    // Controller side
    modport slave (
        input  gamma_present, en_req, load_start, load_abort, s_valid, s_data,
        output s_ready, busy, done, gamma_en, gamma_wr, gamma_wr_addr, gamma_value, checksum
    );
endinterface

`default_nettype wire

// File: rtl/gamma_lut_ctrl.sv
//------------------------------------------------------------------------------
// Module      : gamma_lut_ctrl
// Description : Gamma LUT sequencer: identity fill after reset, then host table
//               loads with gamma_en blanked while the table is rewritten.
//               Define GAMMA_LUT_CTRL_CHECKSUM_EN to build the table checksum.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module gamma_lut_ctrl #(
    parameter int ENTRIES = 768,
    parameter int AW      = 10
) (
    input  wire             clk_sys,
    input  wire             reset_n,
    gamma_lut_ctrl_if.slave bus
);

    localparam logic [AW-1:0] c_last = AW'(ENTRIES - 1);

    typedef enum logic [1:0] {
        S_INIT   = 2'd0,
        S_IDLE   = 2'd1,
        S_LOAD   = 2'd2,
        S_FINISH = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   cnt_q, cnt_d;
    logic            wr_q, wr_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [7:0]      value_q, value_d;
    logic            en_q, en_d;
    logic            ready_q, ready_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    logic            w_start;
    logic            w_take;
    logic            w_last;

    // A byte offered in the same cycle as an abort is dropped.
    assign w_start = (state_q == S_IDLE) && bus.load_start;
    assign w_take  = (state_q == S_LOAD) && bus.s_valid && ready_q && !bus.load_abort;
    assign w_last  = w_take && (cnt_q == c_last);

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            state_q <= S_INIT;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            value_q <= '0;
            en_q    <= 1'b0;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            value_q <= value_d;
            en_q    <= en_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = 1'b0;
        addr_d  = addr_q;
        value_d = value_q;
        en_d    = en_q;
        ready_d = ready_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        case (state_q)
            S_INIT: begin
                en_d    = 1'b0;
                ready_d = 1'b0;
                busy_d  = 1'b1;
                if (!bus.gamma_present) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                end else begin
                    wr_d    = 1'b1;
                    addr_d  = cnt_q;
                    value_d = cnt_q[7:0];
                    cnt_d   = cnt_q + 1'b1;
                    if (cnt_q == c_last) begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                        busy_d  = 1'b0;
                    end
                end
            end

            S_IDLE: begin
                en_d    = bus.en_req;
                ready_d = 1'b0;
                busy_d  = 1'b0;
                if (w_start) begin
                    state_d = S_LOAD;
                    cnt_d   = '0;
                    en_d    = 1'b0;
                    ready_d = 1'b1;
                    busy_d  = 1'b1;
                end
            end

            S_LOAD: begin
                en_d = 1'b0;
                if (bus.load_abort) begin
                    state_d = S_IDLE;
                    ready_d = 1'b0;
                    busy_d  = 1'b0;
                end else if (w_take) begin
                    // Bytes are still counted when no corrector is present.
                    if (bus.gamma_present) begin
                        wr_d    = 1'b1;
                        addr_d  = cnt_q;
                        value_d = bus.s_data;
                    end
                    cnt_d = cnt_q + 1'b1;
                    if (w_last) begin
                        state_d = S_FINISH;
                        cnt_d   = '0;
                        ready_d = 1'b0;
                        done_d  = 1'b1;
                    end
                end
            end

            S_FINISH: begin
                state_d = S_IDLE;
                en_d    = 1'b0;
                ready_d = 1'b0;
                busy_d  = 1'b0;
            end

            default: begin
                state_d = S_INIT;
                cnt_d   = '0;
                busy_d  = 1'b1;
            end
        endcase
    end

    assign bus.gamma_wr      = wr_q;
    assign bus.gamma_wr_addr = addr_q;
    assign bus.gamma_value   = value_q;
    assign bus.gamma_en      = en_q;
    assign bus.s_ready       = ready_q;
    assign bus.busy          = busy_q;
    assign bus.done          = done_q;

`ifdef GAMMA_LUT_CTRL_CHECKSUM_EN
    logic [15:0] acc_q, acc_d;
    logic [15:0] csum_q, csum_d;

    // The published checksum only changes when a load completes.
    always_comb begin
        acc_d  = acc_q;
        csum_d = csum_q;
        if (w_start) begin
            acc_d = '0;
        end else if (w_take) begin
            acc_d = acc_q + {8'h00, bus.s_data};
        end
        if (w_last) begin
            csum_d = acc_q + {8'h00, bus.s_data};
        end
    end

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            acc_q  <= '0;
            csum_q <= '0;
        end else begin
            acc_q  <= acc_d;
            csum_q <= csum_d;
        end
    end

    assign bus.checksum = csum_q;
`else
    assign bus.checksum = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_gamma_lut_ctrl.sv
//------------------------------------------------------------------------------
// Module      : tb_gamma_lut_ctrl
// Description : Scoreboard bench for gamma_lut_ctrl with randomized table loads.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_gamma_lut_ctrl;

    localparam int ENTRIES = 768;
    localparam int AW      = 10;

    logic clk_sys = 1'b0;
    logic reset_n;

    always #5 clk_sys = ~clk_sys;

    gamma_lut_ctrl_if #(.AW(AW)) bus();

    gamma_lut_ctrl #(
        .ENTRIES (ENTRIES),
        .AW      (AW)
    ) dut (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    int          vectors     = 0;
    int          miscompares = 0;
    logic [17:0] exp_q[$];          // {addr, value} of each expected LUT write
    logic [15:0] exp_csum;
    bit          mon_on      = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic smp();
        @(negedge clk_sys);
    endtask

    // Write monitor: every strobe must match the oldest outstanding expectation.
    always @(negedge clk_sys) begin
        if (mon_on && bus.gamma_wr === 1'b1) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_write: got write addr 0x%0h value 0x%0h, required no write",
                         bus.gamma_wr_addr, bus.gamma_value);
            end else begin
                logic [17:0] e;
                e = exp_q.pop_front();
                chk("wr_addr",     32'(bus.gamma_wr_addr), 32'(e[17:8]));
                chk("wr_value",    32'(bus.gamma_value),   32'(e[7:0]));
                chk("wr_gamma_en", 32'(bus.gamma_en),      32'd0);
            end
        end
    end

    task automatic do_reset(input bit present);
        int n;
        bit ok;
        mon_on            = 1'b0;
        exp_q.delete();
        exp_csum          = 16'h0000;
        bus.gamma_present = present;
        bus.load_start    = 1'b0;
        bus.load_abort    = 1'b0;
        bus.s_valid       = 1'b0;
        bus.s_data        = 8'h00;
        reset_n           = 1'b0;
        repeat (3) cyc();
        smp();
        chk("rst_busy",     32'(bus.busy),          32'd1);
        chk("rst_gamma_wr", 32'(bus.gamma_wr),      32'd0);
        chk("rst_addr",     32'(bus.gamma_wr_addr), 32'd0);
        chk("rst_value",    32'(bus.gamma_value),   32'd0);
        chk("rst_gamma_en", 32'(bus.gamma_en),      32'd0);
        chk("rst_s_ready",  32'(bus.s_ready),       32'd0);
        chk("rst_done",     32'(bus.done),          32'd0);
        chk("rst_checksum", 32'(bus.checksum),      32'd0);
        if (present) begin
            for (int i = 0; i < ENTRIES; i++) begin
                exp_q.push_back({10'(i), 8'(i % 256)});
            end
        end
        mon_on = 1'b1;
        cyc();
        reset_n = 1'b1;
        n  = 0;
        ok = 1'b0;
        while (n < 2000) begin
            smp();
            if (!bus.busy) begin
                ok = 1'b1;
                break;
            end
            chk("init_gamma_en", 32'(bus.gamma_en), 32'd0);
            cyc();
            bus.load_start = (n == 40);
            n++;
        end
        bus.load_start = 1'b0;
        if (!ok) begin
            vectors++;
            miscompares++;
            $display("FAIL init_timeout: got busy still high after %0d cycles, required busy low", n);
        end
        repeat (3) cyc();
        smp();
        chk("init_writes_left", 32'(exp_q.size()), 32'd0);
        chk("init_s_ready",     32'(bus.s_ready),  32'd0);
        chk("init_done",        32'(bus.done),     32'd0);
    endtask

    // mode 0: continuous, descending pattern; 1: valid every other cycle; 2: random valid.
    task automatic do_load(input int mode, input int abort_at);
        logic [15:0] sum;
        int          acc;
        int          guard;
        bit          aborted;
        bit          v;
        sum     = 16'h0000;
        acc     = 0;
        guard   = 0;
        aborted = 1'b0;
        bus.load_start = 1'b1;
        cyc();
        bus.load_start = 1'b0;
        while (acc < ENTRIES && guard < 6000) begin
            guard++;
            case (mode)
                0:       v = 1'b1;
                1:       v = 1'(guard % 2);
                default: v = 1'($urandom_range(0, 1));
            endcase
            bus.load_abort = (acc == abort_at);
            if (bus.load_abort) v = 1'b1;
            bus.s_valid = v;
            bus.s_data  = (mode == 0) ? 8'(255 - (acc % 256)) : 8'($urandom_range(0, 255));
            smp();
            chk("load_s_ready",  32'(bus.s_ready),  32'd1);
            chk("load_gamma_en", 32'(bus.gamma_en), 32'd0);
            chk("load_done",     32'(bus.done),     32'd0);
            if (bus.load_abort) begin
                aborted = 1'b1;
                cyc();
                break;
            end
            if (v) begin
                if (bus.gamma_present) exp_q.push_back({10'(acc), bus.s_data});
                sum = sum + {8'h00, bus.s_data};
                acc++;
            end
            cyc();
        end
        bus.s_valid    = 1'b0;
        bus.load_abort = 1'b0;
        if (guard >= 6000) begin
            vectors++;
            miscompares++;
            $display("FAIL load_timeout: got %0d bytes accepted, required %0d", acc, ENTRIES);
        end
        smp();
        if (aborted) begin
            chk("abort_s_ready",  32'(bus.s_ready),  32'd0);
            chk("abort_busy",     32'(bus.busy),     32'd0);
            chk("abort_done",     32'(bus.done),     32'd0);
            chk("abort_checksum", 32'(bus.checksum), 32'(exp_csum));
        end else begin
`ifdef GAMMA_LUT_CTRL_CHECKSUM_EN
            exp_csum = sum;
`else
            exp_csum = 16'h0000;
`endif
            chk("finish_done",     32'(bus.done),     32'd1);
            chk("finish_s_ready",  32'(bus.s_ready),  32'd0);
            chk("finish_busy",     32'(bus.busy),     32'd1);
            chk("finish_checksum", 32'(bus.checksum), 32'(exp_csum));
            cyc();
            smp();
            chk("post_done",     32'(bus.done),     32'd0);
            chk("post_busy",     32'(bus.busy),     32'd0);
            chk("post_s_ready",  32'(bus.s_ready),  32'd0);
            chk("post_checksum", 32'(bus.checksum), 32'(exp_csum));
        end
        repeat (2) cyc();
        smp();
        chk("en_restored",      32'(bus.gamma_en),  32'(bus.en_req));
        chk("load_writes_left", 32'(exp_q.size()),  32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n        = 1'b0;
        bus.en_req     = 1'b0;
        bus.load_start = 1'b0;
        bus.load_abort = 1'b0;
        bus.s_valid    = 1'b0;
        bus.s_data     = 8'h00;
        bus.gamma_present = 1'b1;

        do_reset(1'b1);

        // en_req is followed one clock later while idle
        cyc();
        bus.en_req = 1'b1;
        smp();
        chk("en_latency", 32'(bus.gamma_en), 32'd0);
        cyc();
        smp();
        chk("en_follow", 32'(bus.gamma_en), 32'd1);

        do_load(0, -1);
`ifdef GAMMA_LUT_CTRL_CHECKSUM_EN
        chk("known_checksum", 32'(bus.checksum), 32'h7E80);
`endif
        do_load(1, -1);
        do_load(2, -1);
        do_load(0, 100);
        do_load(2, -1);

        do_reset(1'b0);
        do_load(2, -1);

        mon_on = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/gamma_lut_ctrl.md
Name: gamma_lut_ctrl

Overview:
- Sequencer for the gamma-correction LUT in the video mixer path.
- Drives the write side of the gamma bus: gamma_en, gamma_wr, gamma_wr_addr and gamma_value.
- After reset it fills the LUT with an identity curve. It then accepts host-streamed 768-entry tables over a valid/ready handshake.
- It blanks gamma_en while a table is being rewritten, so the video path never applies a half-written curve.

Parameters:
- ENTRIES, 768, total LUT entries (3 channels × 256); the address counter wraps/terminates at ENTRIES-1.
- AW, 10, width of gamma_wr_addr.

Ports:
- clk_sys  in  1  system clock; also the gamma bus write clock.
- reset_n  in  1  synchronous, active-low reset.
- gamma_present  in  1  gamma_bus[21]; 1 = gamma corrector instantiated.
- en_req  in  1  host-requested gamma enable (level).
- load_start  in  1  single-cycle pulse that begins a table load.
- load_abort  in  1  single-cycle pulse that cancels a load in progress.
- s_valid  in  1  host table byte valid.
- s_data  in  8  host table byte, in order: R[0..255], G[0..255], B[0..255].
- s_ready  out  1  controller accepts s_data.
- busy  out  1  high in INIT/LOAD/FINISH.
- done  out  1  one-cycle pulse when a load completes.
- gamma_en  out  1  gamma_bus[19].
- gamma_wr  out  1  gamma_bus[18], one-cycle write strobe.
- gamma_wr_addr  out  AW  gamma_bus[17:8], {channel[1:0], index[7:0]}.
- gamma_value  out  8  gamma_bus[7:0].
- checksum  out  16  sum of the last loaded table.

Behaviour:
- All outputs are registered.
- Reset (reset_n=0 at a clk_sys edge) produces:
  - state=INIT, cnt=0;
  - gamma_wr=0, gamma_wr_addr=0, gamma_value=0, gamma_en=0;
  - s_ready=0, busy=1, done=0, checksum=0.
- Reset asserted mid-INIT or mid-LOAD discards the operation. The LUT content is then unspecified until INIT completes again.
- States: INIT, IDLE, LOAD, FINISH.
- INIT:
  - If gamma_present=1: one write per cycle, gamma_wr=1, addr=cnt, value=cnt[7:0], for cnt=0..767 (768 cycles), then IDLE.
  - If gamma_present=0: no writes; go to IDLE the next cycle.
  - load_start is ignored in INIT.
- IDLE:
  - busy=0, s_ready=0.
  - gamma_en <= en_req (one-cycle latency).
  - load_start=1 -> LOAD, cnt<=0, checksum accumulator cleared.
- LOAD:
  - s_ready=1 and gamma_en=0 for every cycle in LOAD.
  - A handshake is s_valid & s_ready. The cycle after each handshake: gamma_wr=1, addr=cnt, value=s_data; cnt increments.
  - On the handshake with cnt=ENTRIES-1 -> FINISH. s_ready falls the following cycle; that last write strobe coincides with FINISH.
  - s_valid low stalls with no writes; no timeout.
  - load_start in LOAD is ignored.
  - load_abort in LOAD -> IDLE next cycle. Already-written entries are retained, no done pulse, checksum not updated. A handshake in the same cycle as load_abort is dropped (no write).
- gamma_present=0 during LOAD: handshakes are still accepted and counted, gamma_wr stays 0, done still pulses. gamma_present is sampled every cycle.
- FINISH: lasts one cycle. done=1, checksum output updated, then IDLE; gamma_en follows en_req from the next IDLE cycle.
- gamma_wr is never high in IDLE or FINISH, except the trailing strobe of the last LOAD write.

Optional Feature:
- GAMMA_LUT_CTRL_CHECKSUM_EN defined:
  - 16-bit accumulator adds each accepted s_data (zero-extended, modulo 2^16).
  - Cleared on LOAD entry.
  - checksum is updated in FINISH and holds until the next completed load.
- Not defined: accumulator not built, checksum tied to 0.

Test Plan:
- Reset release, gamma_present=1 -> exactly 768 gamma_wr strobes with addr 0..767 and value=addr[7:0]; busy falls after cycle 768; gamma_en=0 throughout.
- IDLE, en_req 0->1 -> gamma_en=1 one cycle later; load_start -> gamma_en=0 on the next cycle.
- Load with s_data=255-(i%256), s_valid continuously high -> 768 strobes, each one cycle after its handshake. done pulses once, s_ready low afterwards, gamma_en restored. With the macro, checksum=0x17E80 mod 2^16=0x7E80.
- Load with s_valid toggled every other cycle -> writes only after handshakes; addresses remain contiguous 0..767.
- load_abort after 100 handshakes -> 100 writes, IDLE next cycle, no done, checksum unchanged.
- gamma_present=0 at reset and during a load -> no gamma_wr ever; load still accepts 768 bytes and done pulses.
